// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between a UART receiver and a CPU read port.
// A byte is captured once per rising edge of rx_ready. The CPU sees the head
// byte (or the empty marker 16'h8000) on out and removes it with pop.
// A byte that arrives while the FIFO is full and not being popped is dropped,
// and the drop is recorded in a sticky overflow flag.

module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK_100MHz,
  input  logic              clear,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [15:0]       out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_ready_q;
  logic              empty;
  logic              push;
  logic              do_push;
  logic              do_pop;
  logic              drop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push    = rx_ready & ~rx_ready_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~pop;

  // Edge detector history; held high by clear so a level across reset is not a push.
  always_ff @(posedge CLK_100MHz) begin
    if (clear) rx_ready_q <= 1'b1;
    else       rx_ready_q <= rx_ready;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK_100MHz) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr wins so no loss goes unreported.
  always_ff @(posedge CLK_100MHz) begin
    if (clear)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Storage array, no reset: stale contents are never visible because count gates out.
  always_ff @(posedge CLK_100MHz) begin
    if (do_push && !clear) mem[wr_ptr] <= rx_data;
  end

  // CPU-visible word: bit 15 flags empty, otherwise the head byte zero-extended.
  always_comb begin
    out = 16'h8000;
    if (!empty) out = {8'h00, mem[rd_ptr]};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the FIFO.

module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLK_100MHz = 1'b0;
  logic              clear      = 1'b1;
  logic              rx_ready   = 1'b0;
  logic [7:0]        rx_data    = 8'h00;
  logic              pop        = 1'b0;
  logic              ovf_clr    = 1'b0;
  logic [15:0]       out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK_100MHz (CLK_100MHz),
    .clear      (clear),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .pop        (pop),
    .ovf_clr    (ovf_clr),
    .out        (out),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  // Reference model: contents as a queue, overflow bit, last rx_ready level.
  logic [7:0] mq[$];
  bit         m_ovf      = 1'b0;
  bit         m_prev     = 1'b1;
  bit         model_ok   = 1'b0;

  always @(posedge CLK_100MHz) begin
    bit m_push;
    bit m_pop;
    int sz;
    if (clear) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_prev   = 1'b1;
      model_ok = 1'b1;
    end else begin
      sz     = mq.size();
      m_push = rx_ready && !m_prev;
      m_prev = rx_ready;
      m_pop  = pop && (sz > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (sz < DEPTH || m_pop) mq.push_back(rx_data);
        else                     m_ovf = 1'b1;
      end
      if (ovf_clr && !(m_push && sz == DEPTH && !m_pop)) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge CLK_100MHz) begin
    logic [15:0] e_out;
    if (model_ok) begin
      e_out = (mq.size() == 0) ? 16'h8000 : {8'h00, mq[0]};
      checks++;
      if (out !== e_out) begin
        errors++;
        $display("FAIL model_out t=%0t got %h want %h", $time, out, e_out);
      end
      checks++;
      if (count !== (ADDR_W+1)'(mq.size())) begin
        errors++;
        $display("FAIL model_count t=%0t got %0d want %0d", $time, count, mq.size());
      end
      checks++;
      if (full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL model_full t=%0t got %b want %b", $time, full, mq.size() == DEPTH);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL model_ovf t=%0t got %b want %b", $time, overflow, m_ovf);
      end
    end
  end

  task automatic tick();
    @(negedge CLK_100MHz);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    clear = 1'b0;
    tick();
    chk("reset_out", out, 16'h8000);
    chk("reset_count", 16'(count), 16'd0);
    chk("reset_full", 16'(full), 16'd0);
    chk("reset_ovf", 16'(overflow), 16'd0);

    // Single byte in and out.
    rx_ready = 1'b1;
    rx_data  = 8'h41;
    tick();
    chk("push41_out", out, 16'h0041);
    chk("push41_count", 16'(count), 16'd1);
    rx_ready = 1'b0;
    pop_one();
    chk("pop41_out", out, 16'h8000);
    chk("pop41_count", 16'(count), 16'd0);

    // Long rx_ready level is one push.
    rx_ready = 1'b1;
    rx_data  = 8'h55;
    repeat (5) tick();
    rx_ready = 1'b0;
    tick();
    chk("level_count", 16'(count), 16'd1);
    chk("level_out", out, 16'h0055);
    pop_one();

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", 16'(full), 16'd1);
    chk("fill_count", 16'(count), 16'd16);
    push_byte(8'hAA);
    chk("drop_ovf", 16'(overflow), 16'd1);
    chk("drop_count", 16'(count), 16'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", out, {8'h00, 8'(i)});
      pop_one();
    end
    chk("drain_empty", out, 16'h8000);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    rx_ready = 1'b1;
    rx_data  = 8'hBB;
    pop      = 1'b1;
    tick();
    rx_ready = 1'b0;
    pop      = 1'b0;
    chk("fullpp_count", 16'(count), 16'd16);
    chk("fullpp_ovf", 16'(overflow), 16'd0);
    chk("fullpp_head", out, 16'h0011);
    repeat (15) pop_one();
    chk("fullpp_last", out, 16'h00BB);
    pop_one();

    // Interleaved push/pop across pointer wrap.
    push_byte(8'h80);
    for (int k = 1; k <= 40; k++) begin
      rx_ready = 1'b1;
      rx_data  = 8'h80 + 8'(k);
      pop      = 1'b1;
      tick();
      rx_ready = 1'b0;
      pop      = 1'b0;
      chk("wrap_out", out, {8'h00, 8'h80 + 8'(k)});
      chk("wrap_count", 16'(count), 16'd1);
      tick();
    end
    pop_one();
    pop_one();
    chk("empty_pop_count", 16'(count), 16'd0);
    chk("empty_pop_out", out, 16'h8000);

    // Clear beats push and pop; held rx_ready after clear is not a push.
    for (int i = 0; i < 17; i++) push_byte(8'hE0 + 8'(i));
    repeat (13) pop_one();
    chk("pre_clear_count", 16'(count), 16'd3);
    chk("pre_clear_ovf", 16'(overflow), 16'd1);
    clear    = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    pop      = 1'b1;
    tick();
    clear = 1'b0;
    pop   = 1'b0;
    chk("clear_count", 16'(count), 16'd0);
    chk("clear_ovf", 16'(overflow), 16'd0);
    chk("clear_out", out, 16'h8000);
    tick();
    tick();
    chk("held_count", 16'(count), 16'd0);
    rx_ready = 1'b0;
    tick();

    // Randomized traffic: push-heavy phase then pop-heavy phase.
    for (int n = 0; n < 4000; n++) begin
      rx_ready = ($urandom_range(0, 2) != 0);
      rx_data  = 8'($urandom);
      pop      = (n < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      clear    = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear    = 1'b0;
    rx_ready = 1'b0;
    pop      = 1'b0;
    ovf_clr  = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
